// File: rtl/stopwatch_counter_pkg.sv
// Shared definitions for the stopwatch: FSM state encoding and BCD digit geometry.
package stopwatch_counter_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

endpackage

// File: rtl/stopwatch_counter_bcd_digit_inc.sv
// One BCD digit of the ripple counter: advances on carry_in, rolls to zero past max.
module bcd_digit_inc
  import stopwatch_counter_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic [DIGIT_W-1:0] max,
  input  logic               carry_in,
  output logic [DIGIT_W-1:0] next_digit,
  output logic               carry_out
);

  logic w_at_max;

  assign w_at_max  = (digit == max);
  assign carry_out = carry_in & w_at_max;

  always_comb begin
    next_digit = digit;
    if (carry_in) begin
      next_digit = w_at_max ? '0 : digit + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch core: run/pause/lap FSM driving a four-digit BCD counter (ss.hh) with registered outputs.
module stopwatch_counter
  import stopwatch_counter_pkg::*;
#(
  parameter int TENS_MAX = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [15:0] disp,
  output logic        running,
  output logic        lap_active,
  output logic        wrap
);

  state_t r_state;
  state_t w_state_next;

  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] r_count;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] w_count_inc;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] w_count_next;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] w_digit_max;
  logic [NUM_DIGITS:0]                w_carry;
  logic [15:0]                        r_disp;
  logic [15:0]                        w_disp_next;
  logic                               w_count_en;
  logic                               w_clear_count;
  logic                               r_running;
  logic                               r_lap_active;
  logic                               r_wrap;

  // Counting follows the current state, so a tick on the cycle that leaves RUN/LAP still lands.
  assign w_count_en = tick & ((r_state == ST_RUN) | (r_state == ST_LAP));
  assign w_carry[0] = w_count_en;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    assign w_digit_max[i] = (i == NUM_DIGITS - 1) ? DIGIT_W'(TENS_MAX) : BCD_MAX;

    bcd_digit_inc u_digit (
      .digit      (r_count[i]),
      .max        (w_digit_max[i]),
      .carry_in   (w_carry[i]),
      .next_digit (w_count_inc[i]),
      .carry_out  (w_carry[i+1])
    );
  end

  // Only the highest-priority button pulse of a cycle is considered; the rest are dropped.
  always_comb begin
    w_state_next  = r_state;
    w_clear_count = 1'b0;
    if (clear) begin
      if (r_state == ST_PAUSE) begin
        w_state_next  = ST_IDLE;
        w_clear_count = 1'b1;
      end
    end else if (start_stop) begin
      case (r_state)
        ST_IDLE:  w_state_next = ST_RUN;
        ST_RUN:   w_state_next = ST_PAUSE;
        ST_PAUSE: w_state_next = ST_RUN;
        ST_LAP:   w_state_next = ST_PAUSE;
        default:  w_state_next = ST_IDLE;
      endcase
    end else if (lap) begin
      case (r_state)
        ST_RUN:  w_state_next = ST_LAP;
        ST_LAP:  w_state_next = ST_RUN;
        default: w_state_next = r_state;
      endcase
    end
  end

  assign w_count_next = w_clear_count ? '0 : w_count_inc;

  // Entering LAP latches the pre-increment count; staying in LAP holds it.
  always_comb begin
    w_disp_next = w_count_next;
    if (w_state_next == ST_LAP) begin
      w_disp_next = (r_state == ST_LAP) ? r_disp : r_count;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_disp       <= '0;
      r_running    <= 1'b0;
      r_lap_active <= 1'b0;
      r_wrap       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_count      <= w_count_next;
      r_disp       <= w_disp_next;
      r_running    <= (w_state_next == ST_RUN) | (w_state_next == ST_LAP);
      r_lap_active <= (w_state_next == ST_LAP);
      r_wrap       <= w_carry[NUM_DIGITS];
    end
  end

  assign disp       = r_disp;
  assign running    = r_running;
  assign lap_active = r_lap_active;
  assign wrap       = r_wrap;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench for stopwatch_counter: a behavioural model predicts each cycle's outputs.
module tb_stopwatch_counter;

  localparam int TENS_MAX = 5;
  localparam int MAXV     = TENS_MAX * 1000 + 999;

  logic        clk = 1'b0;
  logic        reset = 1'b0, tick = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [15:0] disp;
  logic        running, lap_active, wrap;

  stopwatch_counter #(.TENS_MAX(TENS_MAX)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .disp       (disp),
    .running    (running),
    .lap_active (lap_active),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] disp;
    logic        run;
    logic        lapa;
    logic        wrap;
  } exp_t;

  exp_t sb_q[$];

  int checks   = 0;
  int failures = 0;

  // Model state: time kept as an integer number of hundredths.
  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_LAP} mstate_t;
  mstate_t m_state = M_IDLE;
  int      m_cnt   = 0;
  int      m_disp  = 0;
  logic    m_wrap  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_step(input logic rs, input logic tk, input logic ss,
                            input logic cl, input logic lp);
    mstate_t ns;
    int      nc;
    if (rs) begin
      m_state = M_IDLE; m_cnt = 0; m_disp = 0; m_wrap = 1'b0;
    end else begin
      nc     = m_cnt;
      m_wrap = 1'b0;
      if (tk && (m_state == M_RUN || m_state == M_LAP)) begin
        if (m_cnt == MAXV) begin nc = 0; m_wrap = 1'b1; end
        else nc = m_cnt + 1;
      end
      ns = m_state;
      if (cl) begin
        if (m_state == M_PAUSE) begin ns = M_IDLE; nc = 0; end
      end else if (ss) begin
        ns = (m_state == M_RUN || m_state == M_LAP) ? M_PAUSE : M_RUN;
      end else if (lp) begin
        if (m_state == M_RUN) ns = M_LAP;
        else if (m_state == M_LAP) ns = M_RUN;
      end
      if (ns == M_LAP) begin
        if (m_state != M_LAP) m_disp = m_cnt;
      end else begin
        m_disp = nc;
      end
      m_state = ns;
      m_cnt   = nc;
    end
  endtask

  // One clock: drive inputs, push the prediction, then pop and compare after the edge.
  task automatic cyc(input logic rs, input logic tk, input logic ss, input logic cl, input logic lp);
    exp_t e;
    reset = rs; tick = tk; start_stop = ss; clear = cl; lap = lp;
    model_step(rs, tk, ss, cl, lp);
    sb_q.push_back({to_bcd(m_disp), (m_state == M_RUN || m_state == M_LAP),
                    (m_state == M_LAP), m_wrap});
    @(posedge clk);
    #1;
    reset = 1'b0; tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    e = sb_q.pop_front();
    chk("sb_disp", 32'(disp), 32'(e.disp));
    chk("sb_running", 32'(running), 32'(e.run));
    chk("sb_lap_active", 32'(lap_active), 32'(e.lapa));
    chk("sb_wrap", 32'(wrap), 32'(e.wrap));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    @(posedge clk); #1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_disp", 32'(disp), 32'h0000);
    chk("reset_flags", 32'({running, lap_active, wrap}), 32'h0);

    // Basic run
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(150);
    chk("run150_disp", 32'(disp), 32'h0150);
    chk("run150_running", 32'(running), 32'h1);

    // Roll-over at 59.99
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(5999);
    chk("pre_wrap_disp", 32'(disp), 32'h5999);
    ticks(1);
    chk("wrap_disp", 32'(disp), 32'h0000);
    chk("wrap_pulse", 32'(wrap), 32'h1);
    chk("wrap_running", 32'(running), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrap_one_cycle", 32'(wrap), 32'h0);

    // Lap freeze and release
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(123);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ticks(50);
    chk("lap_frozen_disp", 32'(disp), 32'h0123);
    chk("lap_active", 32'(lap_active), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("lap_release_disp", 32'(disp), 32'h0173);
    chk("lap_release_flag", 32'(lap_active), 32'h0);

    // Pause with coincident tick, then clear
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(42);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("pause_tick_disp", 32'(disp), 32'h0043);
    chk("pause_running", 32'(running), 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pause_holds", 32'(disp), 32'h0043);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clear_disp", 32'(disp), 32'h0000);

    // Clear beats start_stop in PAUSE; clear ignored in RUN
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(5);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("clr_ss_running", 32'(running), 32'h0);
    chk("clr_ss_disp", 32'(disp), 32'h0000);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(7);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clear_in_run_disp", 32'(disp), 32'h0007);
    chk("clear_in_run_running", 32'(running), 32'h1);

    // Reset in LAP with a coincident tick
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(300);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lap_reset_disp", 32'(disp), 32'h0000);
    chk("lap_reset_flags", 32'({running, lap_active, wrap}), 32'h0);

    // Random mix of ticks and sparse button pulses, model-checked every cycle
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0),
          ($urandom_range(0, 19) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 The block SHALL have parameter TENS_MAX, default 5, giving the maximum value of the tens-of-seconds digit (range 1..9).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port tick, input, 1, one-cycle 100 Hz count-enable pulse from the prescaler.
REQ-005 The block SHALL have port start_stop, input, 1, one-cycle debounced button pulse that toggles run/pause.
REQ-006 The block SHALL have port clear, input, 1, one-cycle pulse that zeroes the count when not running.
REQ-007 The block SHALL have port lap, input, 1, one-cycle pulse that freezes or unfreezes the displayed value while running.
REQ-008 The block SHALL have port disp, output, 16, the displayed BCD time {tens_s, units_s, tenths, hundredths}, 4 bits per digit.
REQ-009 The block SHALL have port running, output, 1, high in RUN and LAP.
REQ-010 The block SHALL have port lap_active, output, 1, high in LAP.
REQ-011 The block SHALL have port wrap, output, 1, one-cycle pulse on count roll-over.

Function
REQ-012 FSM states: IDLE (count zero, stopped), RUN, PAUSE, LAP (counting, display frozen).
REQ-013 Transitions: IDLE-start_stop->RUN; RUN-start_stop->PAUSE; PAUSE-start_stop->RUN; PAUSE-clear->IDLE; RUN-lap->LAP; LAP-lap->RUN; LAP-start_stop->PAUSE.
REQ-014 In LAP, clear is ignored; in RUN, clear is ignored; in IDLE, lap and clear are no-ops.
REQ-015 Per-cycle priority: reset > clear > start_stop > lap; a lower-priority pulse in the same cycle is discarded.
REQ-016 Internal count increments by one hundredth on each cycle where tick=1 and the current state is RUN or LAP; the new value is visible the following cycle.
REQ-017 A tick coinciding with a RUN/LAP->PAUSE transition is counted; a tick coinciding with an IDLE/PAUSE->RUN transition is not.
REQ-018 Digit arithmetic: hundredths, tenths and units_s count 0..9; tens_s counts 0..TENS_MAX; each digit's carry-out advances the next digit in the same cycle.
REQ-019 Wrap: TENS_MAX,9,9,9 plus tick SHALL give 0,0,0,0, assert wrap for exactly one cycle, and keep the current state.
REQ-020 disp SHALL equal the internal count in IDLE, RUN and PAUSE; in LAP it SHALL hold the count captured on the entering cycle (pre-increment value if tick coincides).
REQ-021 On LAP->RUN, disp SHALL track the live count from the next cycle; on LAP->PAUSE, disp SHALL show the live count.
REQ-022 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-023 Digit values outside 0..9 (or above TENS_MAX) are unreachable; no error handling is required.

Reset
REQ-024 On reset=1: state IDLE, count 0000, disp 16'h0000, running 0, lap_active 0, wrap 0.
REQ-025 Reset mid-count or in LAP SHALL discard all state, including a coincident tick or button pulse.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding, digit width (4), digit count (4) and the BCD maximum (9).
REQ-027 One sub-module, bcd_digit_inc, SHALL implement a single digit: inputs digit, max, carry_in; outputs next digit and carry_out; instantiated four times in a ripple chain.

Verification
REQ-028 Reset, start_stop, 150 ticks -> disp=16'h0150, running=1.
REQ-029 Preload to 5999 (TENS_MAX=5), one tick -> disp=16'h0000, wrap high for one cycle, running stays 1.
REQ-030 Run to 0123, lap, 50 ticks -> disp=16'h0123, lap_active=1; lap again -> disp=16'h0173 next cycle.
REQ-031 Run to 0042, start_stop with tick in the same cycle -> PAUSE, disp=16'h0043; clear -> IDLE, disp=16'h0000.
REQ-032 In PAUSE, clear and start_stop in the same cycle -> IDLE, running=0; clear during RUN -> count unaffected.
REQ-033 Reset asserted in LAP at 0300 with tick -> next cycle disp=16'h0000, all flags 0.
